// File: rtl/axis_bram_sched_pkg.sv
// Shared types and helpers for the AXIS-BRAM job scheduler slice.
package axis_bram_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_ACTIVE,
      S_DONE
   } sched_state_t;

   localparam logic PORT_HOST   = 1'b0;
   localparam logic PORT_ENGINE = 1'b1;

   // Rows are inclusive; callers truncate the result to their beat-counter width.
   function automatic logic [31:0] calc_expected(input logic [31:0] start_idx,
                                                 input logic [31:0] bound_idx,
                                                 input logic [31:0] words);
      return (bound_idx - start_idx + 32'd1) * words;
   endfunction

endpackage

// File: rtl/axis_bram_job_sched_if.sv
// Command, completion, adapter-control and stream-monitor bundle of the job scheduler.
interface axis_bram_job_sched_if #(
   parameter int BRAM_ADDR_LENGTH = 12
);
   logic                        cmd0_valid;
   logic                        cmd0_ready;
   logic                        cmd0_rw;
   logic [BRAM_ADDR_LENGTH-1:0] cmd0_start;
   logic [BRAM_ADDR_LENGTH-1:0] cmd0_bound;
   logic                        cmd1_valid;
   logic                        cmd1_ready;
   logic                        cmd1_rw;
   logic [BRAM_ADDR_LENGTH-1:0] cmd1_start;
   logic [BRAM_ADDR_LENGTH-1:0] cmd1_bound;
   logic                        done0;
   logic                        done1;
   logic                        err;
   logic                        abort;
   logic                        busy;
   logic                        adp_rw;
   logic                        adp_addr_reload;
   logic [BRAM_ADDR_LENGTH-1:0] adp_start_index;
   logic [BRAM_ADDR_LENGTH-1:0] adp_bound_index;
   logic                        stream_gate;
   logic                        mon_in_valid;
   logic                        mon_in_accep;
   logic                        mon_out_valid;
   logic                        mon_out_accep;
   logic                        mon_out_tlast;

   modport slave (
      input  cmd0_valid, cmd0_rw, cmd0_start, cmd0_bound,
      input  cmd1_valid, cmd1_rw, cmd1_start, cmd1_bound,
      input  abort,
      input  mon_in_valid, mon_in_accep, mon_out_valid, mon_out_accep, mon_out_tlast,
      output cmd0_ready, cmd1_ready, done0, done1, err, busy,
      output adp_rw, adp_addr_reload, adp_start_index, adp_bound_index, stream_gate
   );

   modport master (
      output cmd0_valid, cmd0_rw, cmd0_start, cmd0_bound,
      output cmd1_valid, cmd1_rw, cmd1_start, cmd1_bound,
      output abort,
      output mon_in_valid, mon_in_accep, mon_out_valid, mon_out_accep, mon_out_tlast,
      input  cmd0_ready, cmd1_ready, done0, done1, err, busy,
      input  adp_rw, adp_addr_reload, adp_start_index, adp_bound_index, stream_gate
   );

endinterface

// File: rtl/axis_bram_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last time wins.
module axis_bram_rr_arb2 (
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_grant;

   always_comb begin
      grant = '0;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end

   // Resetting to port 1 hands the first tie to port 0.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_grant <= 1'b1;
      end else if (advance && (grant != 2'b00)) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/axis_bram_job_sched.sv
// Shares one AXIS-BRAM adapter between a host DMA port and a compute-engine port,
// running one transfer job at a time and counting beats to detect completion.
module axis_bram_job_sched
   import axis_bram_sched_pkg::*;
#(
   parameter int BRAM_ADDR_LENGTH   = 12,
   parameter int BRAM_WIDTH_IN_WORD = 36,
   parameter int BEAT_CNT_BITS      = BRAM_ADDR_LENGTH + 7
) (
   input logic                  clk,
   input logic                  rstn,
   axis_bram_job_sched_if.slave bus
);

   sched_state_t                state;
   logic [1:0]                  req;
   logic [1:0]                  grant;
   logic                        take;
   logic                        owner;
   logic                        sel_rw;
   logic [BRAM_ADDR_LENGTH-1:0] sel_start;
   logic [BRAM_ADDR_LENGTH-1:0] sel_bound;
   logic [BEAT_CNT_BITS-1:0]    beat_cnt;
   logic [BEAT_CNT_BITS-1:0]    beat_next;
   logic [BEAT_CNT_BITS-1:0]    expected;
   logic                        beat;
   logic                        final_beat;
   logic                        fin;
   logic                        fin_err;

   logic                        rw_q;
   logic                        reload_q;
   logic [BRAM_ADDR_LENGTH-1:0] start_q;
   logic [BRAM_ADDR_LENGTH-1:0] bound_q;
   logic                        gate_q;
   logic                        busy_q;
   logic                        done0_q;
   logic                        done1_q;
   logic                        err_q;

   assign req  = {bus.cmd1_valid, bus.cmd0_valid};
   assign take = (state == S_IDLE) && (grant != 2'b00);

   axis_bram_rr_arb2 u_arb (
      .clk     (clk),
      .rstn    (rstn),
      .req     (req),
      .advance (take),
      .grant   (grant)
   );

   assign bus.cmd0_ready = (state == S_IDLE) && grant[0];
   assign bus.cmd1_ready = (state == S_IDLE) && grant[1];

   assign sel_rw    = grant[1] ? bus.cmd1_rw    : bus.cmd0_rw;
   assign sel_start = grant[1] ? bus.cmd1_start : bus.cmd0_start;
   assign sel_bound = grant[1] ? bus.cmd1_bound : bus.cmd0_bound;

   assign beat       = rw_q ? (bus.mon_in_valid  && bus.mon_in_accep)
                            : (bus.mon_out_valid && bus.mon_out_accep);
   assign beat_next  = beat_cnt + BEAT_CNT_BITS'(1);
   assign final_beat = (beat_next == expected);

   // Abort wins over a coincident beat; reads must see tlast exactly on the final beat.
   always_comb begin
      fin     = 1'b0;
      fin_err = 1'b0;
      if (bus.abort) begin
         fin     = 1'b1;
         fin_err = 1'b1;
      end else if (beat) begin
         if (final_beat) begin
            fin     = 1'b1;
            fin_err = !rw_q && !bus.mon_out_tlast;
         end else if (!rw_q && bus.mon_out_tlast) begin
            fin     = 1'b1;
            fin_err = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= S_IDLE;
         owner    <= PORT_HOST;
         rw_q     <= 1'b1;
         reload_q <= 1'b0;
         start_q  <= '0;
         bound_q  <= '0;
         gate_q   <= 1'b0;
         busy_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err_q    <= 1'b0;
         beat_cnt <= '0;
         expected <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (take) begin
                  owner <= grant[1];
                  // An inverted range is rejected without touching the adapter.
                  if (sel_bound < sel_start) begin
                     state   <= S_DONE;
                     err_q   <= 1'b1;
                     done0_q <= !grant[1];
                     done1_q <= grant[1];
                  end else begin
                     state    <= S_LOAD;
                     busy_q   <= 1'b1;
                     reload_q <= 1'b1;
                     rw_q     <= sel_rw;
                     start_q  <= sel_start;
                     bound_q  <= sel_bound;
                     beat_cnt <= '0;
                     expected <= BEAT_CNT_BITS'(calc_expected(32'(sel_start), 32'(sel_bound),
                                                              32'(BRAM_WIDTH_IN_WORD)));
                  end
               end
            end
            S_LOAD: begin
               reload_q <= 1'b0;
               state    <= S_SETTLE;
            end
            S_SETTLE: begin
               gate_q <= 1'b1;
               state  <= S_ACTIVE;
            end
            S_ACTIVE: begin
               if (beat) begin
                  beat_cnt <= beat_next;
               end
               if (fin) begin
                  state   <= S_DONE;
                  gate_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  rw_q    <= 1'b1;
                  err_q   <= fin_err;
                  done0_q <= (owner == PORT_HOST);
                  done1_q <= (owner == PORT_ENGINE);
               end
            end
            S_DONE: begin
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               err_q   <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.adp_rw          = rw_q;
   assign bus.adp_addr_reload = reload_q;
   assign bus.adp_start_index = start_q;
   assign bus.adp_bound_index = bound_q;
   assign bus.stream_gate     = gate_q;
   assign bus.busy            = busy_q;
   assign bus.done0           = done0_q;
   assign bus.done1           = done1_q;
   assign bus.err             = err_q;

endmodule

// File: tb/tb_axis_bram_job_sched.sv
// Directed self-checking bench for axis_bram_job_sched.
module tb_axis_bram_job_sched;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_checks = 0;
   int   n_errs   = 0;

   always #5 clk = ~clk;

   axis_bram_job_sched_if #(.BRAM_ADDR_LENGTH(12)) bus_if ();

   axis_bram_job_sched #(
      .BRAM_ADDR_LENGTH   (12),
      .BRAM_WIDTH_IN_WORD (36),
      .BEAT_CNT_BITS      (19)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one command on a single port and returns just after the handshake edge.
   task automatic issue(input int port, input logic rw, input logic [11:0] s, input logic [11:0] b);
      if (port == 0) begin
         bus_if.cmd0_valid = 1'b1; bus_if.cmd0_rw = rw; bus_if.cmd0_start = s; bus_if.cmd0_bound = b;
      end else begin
         bus_if.cmd1_valid = 1'b1; bus_if.cmd1_rw = rw; bus_if.cmd1_start = s; bus_if.cmd1_bound = b;
      end
      #1;
      check("ready0_idle", 32'(bus_if.cmd0_ready), 32'(port == 0));
      check("ready1_idle", 32'(bus_if.cmd1_ready), 32'(port == 1));
      tick();
      bus_if.cmd0_valid = 1'b0;
      bus_if.cmd1_valid = 1'b0;
   endtask

   // n accepted beats, with a stalled cycle before every 8th; tlast on beat tlast_at (reads).
   task automatic beats(input int n, input logic rw, input int tlast_at);
      for (int i = 1; i <= n; i++) begin
         if (i % 8 == 0) begin
            bus_if.mon_in_valid  = rw;
            bus_if.mon_out_valid = !rw;
            bus_if.mon_in_accep  = 1'b0;
            bus_if.mon_out_accep = 1'b0;
            bus_if.mon_out_tlast = 1'b0;
            tick();
         end
         bus_if.mon_in_valid  = rw;
         bus_if.mon_in_accep  = rw;
         bus_if.mon_out_valid = !rw;
         bus_if.mon_out_accep = !rw;
         bus_if.mon_out_tlast = !rw && (i == tlast_at);
         tick();
      end
      bus_if.mon_in_valid  = 1'b0;
      bus_if.mon_in_accep  = 1'b0;
      bus_if.mon_out_valid = 1'b0;
      bus_if.mon_out_accep = 1'b0;
      bus_if.mon_out_tlast = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rw"},     32'(bus_if.adp_rw), 32'd1);
      check({tag, "_reload"}, 32'(bus_if.adp_addr_reload), 32'd0);
      check({tag, "_start"},  32'(bus_if.adp_start_index), 32'd0);
      check({tag, "_bound"},  32'(bus_if.adp_bound_index), 32'd0);
      check({tag, "_gate"},   32'(bus_if.stream_gate), 32'd0);
      check({tag, "_busy"},   32'(bus_if.busy), 32'd0);
      check({tag, "_done0"},  32'(bus_if.done0), 32'd0);
      check({tag, "_done1"},  32'(bus_if.done1), 32'd0);
      check({tag, "_err"},    32'(bus_if.err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bus_if.cmd0_valid = 1'b0; bus_if.cmd0_rw = 1'b0; bus_if.cmd0_start = '0; bus_if.cmd0_bound = '0;
      bus_if.cmd1_valid = 1'b0; bus_if.cmd1_rw = 1'b0; bus_if.cmd1_start = '0; bus_if.cmd1_bound = '0;
      bus_if.abort = 1'b0;
      bus_if.mon_in_valid = 1'b0;  bus_if.mon_in_accep = 1'b0;
      bus_if.mon_out_valid = 1'b0; bus_if.mon_out_accep = 1'b0; bus_if.mon_out_tlast = 1'b0;

      repeat (2) tick();
      check_reset_values("rst");
      check("rst_ready0", 32'(bus_if.cmd0_ready), 32'd0);
      check("rst_ready1", 32'(bus_if.cmd1_ready), 32'd0);
      rstn = 1'b1;
      tick();

      // Port 0 write, rows 0..1 -> 72 beats.
      issue(0, 1'b1, 12'd0, 12'd1);
      check("w_reload_on", 32'(bus_if.adp_addr_reload), 32'd1);
      check("w_start",     32'(bus_if.adp_start_index), 32'd0);
      check("w_bound",     32'(bus_if.adp_bound_index), 32'd1);
      check("w_busy",      32'(bus_if.busy), 32'd1);
      check("w_gate_load", 32'(bus_if.stream_gate), 32'd0);
      tick();
      check("w_reload_off",  32'(bus_if.adp_addr_reload), 32'd0);
      check("w_gate_settle", 32'(bus_if.stream_gate), 32'd0);
      tick();
      check("w_gate_open", 32'(bus_if.stream_gate), 32'd1);
      beats(71, 1'b1, 0);
      check("w_done_early", 32'(bus_if.done0), 32'd0);
      check("w_gate_71",    32'(bus_if.stream_gate), 32'd1);
      beats(1, 1'b1, 0);
      check("w_done0", 32'(bus_if.done0), 32'd1);
      check("w_done1", 32'(bus_if.done1), 32'd0);
      check("w_err",   32'(bus_if.err), 32'd0);
      check("w_gate_closed", 32'(bus_if.stream_gate), 32'd0);
      check("w_busy_done",   32'(bus_if.busy), 32'd0);
      tick();
      check("w_done_pulse", 32'(bus_if.done0), 32'd0);

      // Port 1 read, row 5 only, tlast on beat 36.
      issue(1, 1'b0, 12'd5, 12'd5);
      check("r_rw",    32'(bus_if.adp_rw), 32'd0);
      check("r_start", 32'(bus_if.adp_start_index), 32'd5);
      tick(); tick();
      beats(36, 1'b0, 36);
      check("r_done1",  32'(bus_if.done1), 32'd1);
      check("r_done0",  32'(bus_if.done0), 32'd0);
      check("r_err",    32'(bus_if.err), 32'd0);
      check("r_rw_idle", 32'(bus_if.adp_rw), 32'd1);
      tick();

      // Same read with tlast on beat 20.
      issue(1, 1'b0, 12'd5, 12'd5);
      tick(); tick();
      beats(20, 1'b0, 20);
      check("rt_done1", 32'(bus_if.done1), 32'd1);
      check("rt_err",   32'(bus_if.err), 32'd1);
      tick();

      // Both ports requesting for four jobs: grants alternate 0,1,0,1.
      bus_if.cmd0_valid = 1'b1; bus_if.cmd0_rw = 1'b1; bus_if.cmd0_start = 12'd0; bus_if.cmd0_bound = 12'd0;
      bus_if.cmd1_valid = 1'b1; bus_if.cmd1_rw = 1'b1; bus_if.cmd1_start = 12'd0; bus_if.cmd1_bound = 12'd0;
      #1;
      for (int j = 0; j < 4; j++) begin
         check("rr_ready0", 32'(bus_if.cmd0_ready), 32'(j % 2 == 0));
         check("rr_ready1", 32'(bus_if.cmd1_ready), 32'(j % 2 == 1));
         tick();
         check("rr_busy_ready0", 32'(bus_if.cmd0_ready), 32'd0);
         check("rr_busy_ready1", 32'(bus_if.cmd1_ready), 32'd0);
         tick(); tick();
         beats(36, 1'b1, 0);
         check("rr_done0", 32'(bus_if.done0), 32'(j % 2 == 0));
         check("rr_done1", 32'(bus_if.done1), 32'(j % 2 == 1));
         check("rr_err",   32'(bus_if.err), 32'd0);
         if (j == 3) begin
            bus_if.cmd0_valid = 1'b0;
            bus_if.cmd1_valid = 1'b0;
         end
         tick();
      end

      // Inverted range: rejected with error, adapter untouched.
      issue(0, 1'b1, 12'd7, 12'd3);
      check("inv_done0",  32'(bus_if.done0), 32'd1);
      check("inv_err",    32'(bus_if.err), 32'd1);
      check("inv_reload", 32'(bus_if.adp_addr_reload), 32'd0);
      check("inv_gate",   32'(bus_if.stream_gate), 32'd0);
      check("inv_start",  32'(bus_if.adp_start_index), 32'd0);
      tick();
      check("inv_done_pulse", 32'(bus_if.done0), 32'd0);
      check("inv_reload2",    32'(bus_if.adp_addr_reload), 32'd0);

      // Abort during LOAD is ignored; abort after 10 beats ends the job.
      issue(0, 1'b1, 12'd0, 12'd0);
      bus_if.abort = 1'b1;
      tick();
      bus_if.abort = 1'b0;
      check("ab_load_done", 32'(bus_if.done0), 32'd0);
      check("ab_load_busy", 32'(bus_if.busy), 32'd1);
      tick();
      beats(10, 1'b1, 0);
      check("ab_gate_before", 32'(bus_if.stream_gate), 32'd1);
      bus_if.abort = 1'b1;
      tick();
      bus_if.abort = 1'b0;
      check("ab_gate",  32'(bus_if.stream_gate), 32'd0);
      check("ab_done0", 32'(bus_if.done0), 32'd1);
      check("ab_err",   32'(bus_if.err), 32'd1);
      check("ab_busy",  32'(bus_if.busy), 32'd0);
      check("ab_rw",    32'(bus_if.adp_rw), 32'd1);
      tick();

      // Reset mid-ACTIVE, then a normal job.
      issue(1, 1'b0, 12'd2, 12'd2);
      tick(); tick();
      beats(5, 1'b0, 0);
      rstn = 1'b0;
      tick();
      check_reset_values("mid");
      rstn = 1'b1;
      tick();
      check("mid_no_done1", 32'(bus_if.done1), 32'd0);
      check("mid_no_err",   32'(bus_if.err), 32'd0);
      issue(0, 1'b1, 12'd0, 12'd0);
      check("post_reload", 32'(bus_if.adp_addr_reload), 32'd1);
      tick(); tick();
      beats(36, 1'b1, 0);
      check("post_done0", 32'(bus_if.done0), 32'd1);
      check("post_err",   32'(bus_if.err), 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
